adder_arbiter: RTL and testbench



---
 rtl/adder_arb_pkg.sv | 38 +++
 rtl/adder_arbiter_if.sv | 29 ++
 rtl/adder.sv | 9 +
 rtl/adder_arbiter_rr_picker.sv | 37 +++
 rtl/adder_arbiter.sv | 140 ++++++++++++++
 tb/tb_adder_arbiter.sv | 220 ++++++++++++++++++++++
 6 files changed

// File: rtl/adder_arb_pkg.sv
// Shared types and helpers for the round-robin adder arbiter.
// Optional statistics counters are enabled with ADDER_ARB_STATS_EN.
package adder_arb_pkg;

   localparam int OPW    = 6;
   localparam int SUMW   = 7;
   localparam int MAXREQ = 8;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_t;

   // First set bit of req at or above ptr, wrapping modulo n; one-hot result.
   function automatic logic [MAXREQ-1:0] rr_pick(
      input logic [MAXREQ-1:0] req,
      input logic [2:0]        ptr,
      input int                n
   );
      logic [MAXREQ-1:0] g;
      logic              hit;
      int                idx;
      g   = '0;
      hit = 1'b0;
      for (int k = 0; k < MAXREQ; k++) begin
         if (k < n) begin
            idx = (int'(ptr) + k) % n;
            if (!hit && req[idx[2:0]]) begin
               g[idx[2:0]] = 1'b1;
               hit         = 1'b1;
            end
         end
      end
      return g;
   endfunction

endpackage

// File: rtl/adder_arbiter_if.sv
// Requester and response handshake bundle for adder_arbiter.
// Used unchanged whether or not ADDER_ARB_STATS_EN is defined.
interface adder_arbiter_if
   import adder_arb_pkg::*;
#(
   parameter int NREQ = 4
);
   localparam int IDW = $clog2(NREQ);

   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [OPW*NREQ-1:0] req_x;
   logic [OPW*NREQ-1:0] req_y;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [SUMW-1:0]     rsp_s;
   logic [IDW-1:0]      rsp_id;

   modport master (
      output req_valid, req_x, req_y, rsp_ready,
      input  req_ready, rsp_valid, rsp_s, rsp_id
   );

   modport slave (
      input  req_valid, req_x, req_y, rsp_ready,
      output req_ready, rsp_valid, rsp_s, rsp_id
   );

endinterface

// File: rtl/adder.sv
// Existing 6-bit combinational adder; s[6] is the carry-out.
// Unaffected by ADDER_ARB_STATS_EN.
module adder (
   input  logic [5:0] x,
   input  logic [5:0] y,
   output logic [6:0] s
);
   assign s = {1'b0, x} + {1'b0, y};
endmodule

// File: rtl/adder_arbiter_rr_picker.sv
// Combinational round-robin priority select over NREQ requesters.
// Unaffected by ADDER_ARB_STATS_EN.
module adder_arbiter_rr_picker
   import adder_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IDW-1:0]  i_ptr,
   output logic [NREQ-1:0] o_grant,
   output logic [IDW-1:0]  o_gid,
   output logic            o_any
);
   logic [MAXREQ-1:0] w_req8;
   logic [2:0]        w_ptr3;
   logic [MAXREQ-1:0] w_g8;

   always_comb begin
      w_req8             = '0;
      w_req8[NREQ-1:0]   = i_req;
      w_ptr3             = '0;
      w_ptr3[IDW-1:0]    = i_ptr;
   end

   assign w_g8    = rr_pick(w_req8, w_ptr3, NREQ);
   assign o_grant = w_g8[NREQ-1:0];
   assign o_any   = |w_g8;

   always_comb begin
      o_gid = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (o_grant[i]) o_gid = IDW'(i);
      end
   end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one 6-bit adder between NREQ requesters.
// Define ADDER_ARB_STATS_EN to add grant_cnt / carry_cnt counters.
module adder_arbiter
   import adder_arb_pkg::*;
#(
   parameter  int NREQ = 4,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   adder_arbiter_if.slave       bus
`ifdef ADDER_ARB_STATS_EN
   ,
   output logic [16*NREQ-1:0]   grant_cnt,
   output logic [15:0]          carry_cnt
`endif
);
   state_t          r_state;
   logic [IDW-1:0]  r_rr_ptr;
   logic [OPW-1:0]  r_op_x;
   logic [OPW-1:0]  r_op_y;
   logic [IDW-1:0]  r_op_id;
   logic            r_rsp_valid;
   logic [SUMW-1:0] r_rsp_s;
   logic [IDW-1:0]  r_rsp_id;

   logic [NREQ-1:0] w_grant;
   logic [IDW-1:0]  w_gid;
   logic            w_any;
   logic [IDW-1:0]  w_ptr_nxt;
   logic [OPW-1:0]  w_gx;
   logic [OPW-1:0]  w_gy;
   logic [SUMW-1:0] w_sum;
   logic            w_req_hs;
   logic            w_rsp_hs;

   adder_arbiter_rr_picker #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_pick (
      .i_req   (bus.req_valid),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_grant),
      .o_gid   (w_gid),
      .o_any   (w_any)
   );

   // The adder sees only the registered operands.
   adder u_adder (
      .x (r_op_x),
      .y (r_op_y),
      .s (w_sum)
   );

   always_comb begin
      w_gx = '0;
      w_gy = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_grant[i]) begin
            w_gx = bus.req_x[OPW*i +: OPW];
            w_gy = bus.req_y[OPW*i +: OPW];
         end
      end
   end

   assign w_ptr_nxt = (w_gid == IDW'(NREQ-1)) ? '0 : w_gid + 1'b1;
   assign w_req_hs  = (r_state == IDLE) && w_any && !rst;
   assign w_rsp_hs  = r_rsp_valid && bus.rsp_ready;

   assign bus.req_ready = w_req_hs ? w_grant : '0;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_s     = r_rsp_s;
   assign bus.rsp_id    = r_rsp_id;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_rr_ptr    <= '0;
         r_op_x      <= '0;
         r_op_y      <= '0;
         r_op_id     <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_s     <= '0;
         r_rsp_id    <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_op_x   <= w_gx;
                  r_op_y   <= w_gy;
                  r_op_id  <= w_gid;
                  r_rr_ptr <= w_ptr_nxt;
                  r_state  <= EXEC;
               end
            end
            EXEC: begin
               r_rsp_s     <= w_sum;
               r_rsp_id    <= r_op_id;
               r_rsp_valid <= 1'b1;
               r_state     <= RESP;
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef ADDER_ARB_STATS_EN
   logic [15:0] r_gcnt [NREQ];
   logic [15:0] r_ccnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREQ; i++) r_gcnt[i] <= '0;
         r_ccnt <= '0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (w_req_hs && w_grant[i] && r_gcnt[i] != 16'hFFFF)
               r_gcnt[i] <= r_gcnt[i] + 16'd1;
         end
         if (w_rsp_hs && r_rsp_s[SUMW-1] && r_ccnt != 16'hFFFF)
            r_ccnt <= r_ccnt + 16'd1;
      end
   end

   for (genvar g = 0; g < NREQ; g++) begin : g_cnt
      assign grant_cnt[16*g +: 16] = r_gcnt[g];
   end
   assign carry_cnt = r_ccnt;
`else
   logic w_unused;
   assign w_unused = w_rsp_hs;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed, table-driven bench for adder_arbiter (NREQ=4).
// Define ADDER_ARB_STATS_EN to also check the statistics counters.
module tb_adder_arbiter;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   adder_arbiter_if #(.NREQ(4)) bus ();

`ifdef ADDER_ARB_STATS_EN
   logic [63:0] grant_cnt;
   logic [15:0] carry_cnt;
`endif

   adder_arbiter #(.NREQ(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus)
`ifdef ADDER_ARB_STATS_EN
      ,
      .grant_cnt (grant_cnt),
      .carry_cnt (carry_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int id;
      int x;
      int y;
      int s;
   } vec_t;

   vec_t tbl [8];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   // One isolated request through requester id, junk on the others.
   task automatic do_op(input int id, input int x, input int y,
                        input int s);
      for (int k = 0; k < 4; k++) begin
         bus.req_x[6*k +: 6] = 6'($urandom);
         bus.req_y[6*k +: 6] = 6'($urandom);
      end
      bus.req_x[6*id +: 6] = 6'(x);
      bus.req_y[6*id +: 6] = 6'(y);
      bus.req_valid = 4'(1 << id);
      bus.rsp_ready = 1'b1;
      #1;
      chk("op_req_ready", 32'(bus.req_ready), 32'(1 << id));
      tick();
      bus.req_valid = '0;
      for (int k = 0; k < 4; k++) begin
         bus.req_x[6*k +: 6] = 6'($urandom);
      end
      #1;
      chk("op_exec_valid", 32'(bus.rsp_valid), 0);
      tick();
      #1;
      chk("op_rsp_valid", 32'(bus.rsp_valid), 1);
      chk("op_rsp_s", 32'(bus.rsp_s), 32'(s));
      chk("op_rsp_id", 32'(bus.rsp_id), 32'(id));
      tick();
      #1;
      chk("op_rsp_drop", 32'(bus.rsp_valid), 0);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      tbl[0] = '{id: 0, x: 63, y: 1,  s: 64};
      tbl[1] = '{id: 1, x: 0,  y: 0,  s: 0};
      tbl[2] = '{id: 2, x: 21, y: 10, s: 31};
      tbl[3] = '{id: 3, x: 63, y: 63, s: 126};
      tbl[4] = '{id: 3, x: 32, y: 32, s: 64};
      tbl[5] = '{id: 0, x: 5,  y: 7,  s: 12};
      tbl[6] = '{id: 2, x: 40, y: 30, s: 70};
      tbl[7] = '{id: 1, x: 1,  y: 62, s: 63};

      rst           = 1'b1;
      bus.req_valid = 4'b1111;
      bus.req_x     = '0;
      bus.req_y     = '0;
      bus.rsp_ready = 1'b1;
      tick();
      tick();
      #1;
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("rst_rsp_s", 32'(bus.rsp_s), 0);
      chk("rst_rsp_id", 32'(bus.rsp_id), 0);
      chk("rst_req_ready", 32'(bus.req_ready), 0);
      bus.req_valid = '0;
      rst = 1'b0;
      tick();
      #1;
      chk("idle_no_req", 32'(bus.req_ready), 0);

      for (int i = 0; i < 8; i++)
         do_op(tbl[i].id, tbl[i].x, tbl[i].y, tbl[i].s);

      // Round robin with all requesters valid; rr_ptr starts at 0.
      do_reset();
      for (int k = 0; k < 4; k++) begin
         bus.req_x[6*k +: 6] = 6'(k + 10);
         bus.req_y[6*k +: 6] = 6'(k + 20);
      end
      bus.req_valid = 4'b1111;
      bus.rsp_ready = 1'b1;
      for (int n = 0; n < 5; n++) begin
         #1;
         chk("rr_grant", 32'(bus.req_ready), 32'(1 << (n % 4)));
         tick();
         #1;
         chk("rr_exec_valid", 32'(bus.rsp_valid), 0);
         chk("rr_exec_ready", 32'(bus.req_ready), 0);
         tick();
         #1;
         chk("rr_rsp_valid", 32'(bus.rsp_valid), 1);
         chk("rr_rsp_id", 32'(bus.rsp_id), 32'(n % 4));
         chk("rr_rsp_s", 32'(bus.rsp_s), 32'(2 * (n % 4) + 30));
         tick();
      end

      // Backpressure; rr_ptr is now 1.
      bus.req_x[6 +: 6] = 6'd21;
      bus.req_y[6 +: 6] = 6'd10;
      bus.req_valid = 4'b0010;
      bus.rsp_ready = 1'b0;
      #1;
      chk("bp_grant", 32'(bus.req_ready), 32'b0010);
      tick();
      bus.req_valid = 4'b1111;
      tick();
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("bp_valid", 32'(bus.rsp_valid), 1);
         chk("bp_s", 32'(bus.rsp_s), 31);
         chk("bp_id", 32'(bus.rsp_id), 1);
         chk("bp_req_ready", 32'(bus.req_ready), 0);
         tick();
      end
      bus.rsp_ready = 1'b1;
      #1;
      chk("bp_hs_valid", 32'(bus.rsp_valid), 1);
      tick();
      #1;
      chk("bp_next_grant", 32'(bus.req_ready), 32'b0100);
      chk("bp_drop", 32'(bus.rsp_valid), 0);

      // Reset while in EXEC discards the operation.
      bus.req_valid = 4'b0100;
      tick();
      bus.req_valid = '0;
      rst = 1'b1;
      #1;
      chk("rm_valid_async", 32'(bus.rsp_valid), 0);
      for (int c = 0; c < 2; c++) begin
         tick();
         #1;
         chk("rm_valid_rst", 32'(bus.rsp_valid), 0);
      end
      rst = 1'b0;
      for (int c = 0; c < 2; c++) begin
         tick();
         #1;
         chk("rm_valid_after", 32'(bus.rsp_valid), 0);
      end
      bus.req_valid = 4'b1010;
      #1;
      chk("rm_grant", 32'(bus.req_ready), 32'b0010);
      tick();
      bus.req_valid = '0;
      tick();
      #1;
      chk("rm_rsp_id", 32'(bus.rsp_id), 1);
      tick();

      // Every operand pair through requester 2.
      for (int x = 0; x < 64; x++)
         for (int y = 0; y < 64; y++)
            do_op(2, x, y, x + y);

`ifdef ADDER_ARB_STATS_EN
      do_reset();
      do_op(1, 63, 1, 64);
      do_op(1, 40, 40, 80);
      do_op(1, 1, 2, 3);
      chk("st_grant1", 32'(grant_cnt[31:16]), 3);
      chk("st_grant0", 32'(grant_cnt[15:0]), 0);
      chk("st_carry", 32'(carry_cnt), 2);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
